mul_exe_unit: RTL and testbench
===============================

Name: mul_exe_unit

Overview:
- EXE-stage consumer of the multiply/HI-LO control bundle registered out of the ID/EXE multiply pipeline register.
- Executes mult/multu/madd/msub with an iterative shift-add multiplier, and mthi/mtlo with direct writes.
- Owns the architectural HI/LO registers and drives busy back to hazard control, which deasserts that pipeline register's EN.

Parameters:
BITS_PER_CYCLE, 2, multiplier bits retired per CALC cycle; legal values 1, 2, 4; CALC length N = 32/BITS_PER_CYCLE.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
sign  in  1  1 = signed operands
a  in  32  multiplicand
b  in  32  multiplier
hilo  in  2  direct-write select: [1] = HI, [0] = LO
we  in  1  direct write of data into HI/LO per hilo
en_c  in  1  accumulate the product into {HI,LO}
add_sub  in  1  accumulate mode: 0 = add, 1 = subtract
data  in  32  direct-write value
mul  in  1  start a multiply
exe_stall  in  1  EXE held by another cause; current instruction will not retire
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  stall request to hazard control
done  out  1  one-cycle pulse: multiply result commits at this edge

Behaviour:
- States: IDLE, CALC, FIN, HOLD.
- Reset: state IDLE, hi = 0, lo = 0, done = 0, counter = 0, internal datapath = 0. busy is forced to 0 while rst = 1.
- Reset mid-operation: the multiply is abandoned immediately. It is not resumed, and HI/LO read 0.
- busy (combinational) = ~rst & ((state == IDLE & mul) | state == CALC). It is 0 in FIN and HOLD.
- IDLE, mul = 1:
  - Latch sign, en_c and add_sub.
  - Latch magnitudes: |a| and |b| when sign = 1, raw values otherwise. -2^31 maps to 0x80000000 unsigned.
  - Latch negate flag = sign & (a[31] ^ b[31]).
  - Clear the 64-bit product and the counter; go to CALC.
  - we is ignored whenever mul = 1.
- IDLE, mul = 0, we = 1: write data into HI if hilo[1], into LO if hilo[0], at this edge. State stays IDLE and busy stays 0.
- IDLE, mul = 0, we = 0: no action.
- CALC:
  - Each cycle, add the multiplicand × the next BITS_PER_CYCLE low bits of the multiplier into the product, then shift.
  - Counter counts 0..N-1; at N-1 go to FIN. N = 16 cycles by default.
  - All inputs are ignored.
- FIN:
  - Compute p = negate ? -product : product, modulo 2^64.
  - Commit at this edge: {HI,LO} = en_c ? (add_sub ? {HI,LO} - p : {HI,LO} + p) : p, all modulo 2^64.
  - done = 1 for this cycle.
  - Next state: exe_stall ? HOLD : IDLE.
- HOLD: the same instruction is still presented; inputs are ignored (no restart, no direct write). Leave to IDLE when exe_stall = 0.
- exe_stall does not affect IDLE or CALC. A multiply may start while exe_stall = 1.
- Latency with mul presented in cycle 0:
  - busy is high in cycles 0..N; CALC occupies cycles 1..N.
  - FIN is cycle N+1; the new hi/lo are visible in cycle N+2.
  - Default: 17 busy cycles.
- Back-to-back: a new mul may be presented in the cycle immediately after FIN/HOLD and starts normally.
- hi/lo hold their value during CALC, so mfhi/mflo forwarding reads pre-multiply values. The pipeline does not issue these reads while busy.

Decomposition:
- Shared package mul_pkg holds:
  - the state enum
  - HILO_HI = 2'b10, HILO_LO = 2'b01
  - the legal BITS_PER_CYCLE check
- Sub-module mul_iter_core: the magnitude shift-add datapath. It takes start, operand magnitudes and the counter, and returns the 64-bit unsigned product. The FSM, sign fix-up, accumulate and HI/LO registers stay in the top module.

Test Plan:
- Unsigned multiply: a = b = 0xFFFFFFFF, sign = 0, mul = 1 -> busy for 17 cycles, done in cycle 17, HI = 0xFFFFFFFE, LO = 0x00000001.
- Signed multiply, two cases:
  - a = 0xFFFFFFFD, b = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - a = b = 0x80000000 -> HI = 0x40000000, LO = 0.
- Direct writes:
  - we = 1, hilo = 10, data = 0x12345678 -> HI = 0x12345678 next cycle, LO unchanged, busy never asserted.
  - hilo = 11 -> both HI and LO written.
- Accumulate:
  - Add: HI = 0, LO = 0xFFFFFFFF; en_c = 1, add_sub = 0, a = b = 1 -> HI = 1, LO = 0.
  - Subtract: from HI = LO = 0 with add_sub = 1 -> HI = LO = 0xFFFFFFFF.
- Stall hold: mul held with exe_stall = 1 through FIN plus 3 cycles -> state HOLD, no second multiply, madd applied exactly once. After exe_stall drops, a new mul restarts.
- Reset mid-operation: rst in CALC cycle 5 -> busy = 0 and HI = LO = 0 next cycle, state IDLE, done never pulses.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the EXE-stage multiply unit.
//   state_t   : multiply FSM states
//   HILO_HI/LO: bit masks of the direct-write select (hilo) input
//   bpc_legal : legality check for the BITS_PER_CYCLE parameter
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [1:0] HILO_HI = 2'b10;
  localparam logic [1:0] HILO_LO = 2'b01;

  function automatic bit bpc_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4);
  endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Unsigned iterative shift-add multiplier datapath.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : load operand magnitudes and clear the product
//   step          : retire BITS_PER_CYCLE multiplier bits this cycle
//   a_mag, b_mag  : 32-bit unsigned multiplicand / multiplier
//   count         : iteration index, selects which multiplier digit to retire
//   product       : 64-bit unsigned product (complete after 32/BITS_PER_CYCLE steps)
module mul_iter_core #(
  parameter int BITS_PER_CYCLE = 2,
  parameter int CW             = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic [31:0]   a_mag,
  input  logic [31:0]   b_mag,
  input  logic [CW-1:0] count,
  output logic [63:0]   product
);

  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [63:0] product_reg;
  logic [4:0]  shamt;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [63:0] mcand_ext;
  logic [63:0] term [BITS_PER_CYCLE];
  logic [63:0] partial_sum;

  // Bit position of the digit retired in this step.
  assign shamt     = 5'(32'(count) * BITS_PER_CYCLE);
  assign digit     = mplier_reg[shamt +: BITS_PER_CYCLE];
  assign mcand_ext = {32'b0, mcand_reg};

  // One shifted copy of the multiplicand per multiplier bit in the digit.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign term[gi] = digit[gi] ? (mcand_ext << (shamt + 5'(gi))) : 64'd0;
    end
  endgenerate

  always_comb begin
    partial_sum = 64'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      partial_sum = partial_sum + term[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg   <= 32'd0;
      mplier_reg  <= 32'd0;
      product_reg <= 64'd0;
    end else if (start) begin
      mcand_reg   <= a_mag;
      mplier_reg  <= b_mag;
      product_reg <= 64'd0;
    end else if (step) begin
      product_reg <= product_reg + partial_sum;
    end
  end

  assign product = product_reg;

endmodule

// File: rtl/mul_exe_unit.sv
// EXE-stage multiply / HI-LO unit: mult, multu, madd, msub via an iterative
// multiplier, mthi/mtlo via direct writes. Owns the HI/LO registers.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   sign            : signed operands
//   a, b            : multiplicand, multiplier
//   hilo, we, data  : direct write of data into HI ([1]) and/or LO ([0])
//   en_c, add_sub   : accumulate product into {HI,LO}, 0 = add / 1 = subtract
//   mul             : start a multiply
//   exe_stall       : EXE held elsewhere; FIN waits in HOLD while set
//   hi, lo          : architectural HI/LO
//   busy            : stall request to hazard control
//   done            : pulse in the cycle whose closing edge commits the result
module mul_exe_unit
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  hilo,
  input  logic        we,
  input  logic        en_c,
  input  logic        add_sub,
  input  logic [31:0] data,
  input  logic        mul,
  input  logic        exe_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
      $error("mul_exe_unit: BITS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [31:0]   hi_reg, lo_reg;
  logic          en_c_reg, add_sub_reg, neg_reg;
  logic [31:0]   a_mag, b_mag;
  logic          start;
  logic [63:0]   product, p, acc, commit_val;

  // |x| in two's complement; 0x80000000 maps onto itself, which is its
  // correct unsigned magnitude.
  assign a_mag = (sign & a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (sign & b[31]) ? (~b + 32'd1) : b;
  assign start = (state_reg == IDLE) & mul;

  mul_iter_core #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE),
    .CW            (CW)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .step   (state_reg == CALC),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .count  (count_reg),
    .product(product)
  );

  assign p          = neg_reg ? (~product + 64'd1) : product;
  assign acc        = {hi_reg, lo_reg};
  assign commit_val = en_c_reg ? (add_sub_reg ? acc - p : acc + p) : p;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (mul) state_next = CALC;
      CALC: if (count_reg == LAST) state_next = FIN;
      FIN:  state_next = exe_stall ? HOLD : IDLE;
      HOLD: if (!exe_stall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      en_c_reg    <= 1'b0;
      add_sub_reg <= 1'b0;
      neg_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mul) begin
            en_c_reg    <= en_c;
            add_sub_reg <= add_sub;
            neg_reg     <= sign & (a[31] ^ b[31]);
            count_reg   <= '0;
          end else if (we) begin
            if ((hilo & HILO_HI) != 2'b00) hi_reg <= data;
            if ((hilo & HILO_LO) != 2'b00) lo_reg <= data;
          end
        end
        CALC: count_reg <= count_reg + 1'b1;
        FIN:  {hi_reg, lo_reg} <= commit_val;
        default: ;
      endcase
    end
  end

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign busy = ~rst & (start | (state_reg == CALC));
  assign done = ~rst & (state_reg == FIN);

endmodule

// File: tb/tb_mul_exe_unit.sv
// Self-checking bench for mul_exe_unit: randomized multiplies and direct writes
// against an arithmetic model, checked by a scoreboard monitor on done.
module tb_mul_exe_unit;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, sign, we, en_c, add_sub, mul, exe_stall;
  logic [31:0] a, b, data;
  logic [1:0]  hilo;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  logic [63:0] model_hilo;
  logic [63:0] exp_q[$];

  mul_exe_unit #(.BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst), .sign(sign), .a(a), .b(b), .hilo(hilo), .we(we),
    .en_c(en_c), .add_sub(add_sub), .data(data), .mul(mul),
    .exe_stall(exe_stall), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width product by plain arithmetic, then accumulate mod 2^64.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input logic ec, input logic as_,
                                          input logic [63:0] accv);
    logic [63:0] prod;
    if (s) prod = 64'(longint'($signed(x)) * longint'($signed(y)));
    else   prod = {32'b0, x} * {32'b0, y};
    if (!ec)     return prod;
    else if (as_) return accv - prod;
    else          return accv + prod;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: on every done pulse, the following cycle must show
  // the next queued expected {HI,LO}.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          @(negedge clk); #1;
          chk("mul_result", {hi, lo}, e);
          $display("mul #%0d: hi=%h lo=%h", n_txn, hi, lo);
          n_txn++;
        end
      end
    end
  end

  task automatic run_mul(input logic [31:0] ta, input logic [31:0] tb2, input logic ts,
                         input logic tec, input logic tas, input bit stall);
    logic [63:0] e;
    e = ref_mul(ta, tb2, ts, tec, tas, model_hilo);
    model_hilo = e;
    exp_q.push_back(e);
    @(negedge clk);
    a = ta; b = tb2; sign = ts; en_c = tec; add_sub = tas; mul = 1'b1;
    we = 1'($urandom); hilo = 2'b11; data = $urandom;
    exe_stall = stall ? 1'b1 : 1'($urandom);
    #1 chk("busy_start", {63'd0, busy}, 64'd1);
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      if (!stall) begin
        mul = 1'b0; a = $urandom; b = $urandom; sign = 1'($urandom);
        en_c = 1'($urandom); add_sub = 1'($urandom); we = 1'($urandom);
        data = $urandom; exe_stall = 1'($urandom);
      end
      #1 chk("busy_calc", {62'd0, busy, done}, 64'd2);
    end
    @(negedge clk);
    if (!stall) exe_stall = 1'b0;
    #1 chk("fin_done", {62'd0, busy, done}, 64'd1);
    if (stall) begin
      repeat (3) begin
        @(negedge clk); #1 chk("hold", {62'd0, busy, done}, 64'd0);
      end
      @(negedge clk); exe_stall = 1'b0; mul = 1'b0;
      #1 chk("hold_exit", {62'd0, busy, done}, 64'd0);
    end
    mul = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] hl, input logic [31:0] d);
    @(negedge clk);
    mul = 1'b0; we = 1'b1; hilo = hl; data = d; a = $urandom; b = $urandom;
    #1 chk("wr_busy", {63'd0, busy}, 64'd0);
    if (hl[1]) model_hilo[63:32] = d;
    if (hl[0]) model_hilo[31:0]  = d;
    @(negedge clk); we = 1'b0;
    #1 chk("wr_hilo", {hi, lo}, model_hilo);
    $display("write hilo=%b data=%h: hi=%h lo=%h", hl, d, hi, lo);
  endtask

  task automatic chk_const(input string name, input logic [63:0] exp);
    @(negedge clk); #1 chk(name, {hi, lo}, exp);
  endtask

  initial begin
    rst = 1'b1; mul = 1'b1; we = 1'b1; sign = 1'b0; en_c = 1'b0; add_sub = 1'b0;
    a = 32'd3; b = 32'd5; hilo = 2'b11; data = 32'hDEAD_BEEF; exe_stall = 1'b0;
    model_hilo = 64'd0;
    #1 chk("rst_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0; mul = 1'b0; we = 1'b0;
    #1 chk("rst_state", {hi, lo, 30'd0, busy, done}, 64'd0);

    // Directed cases.
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    chk_const("multu_max", 64'hFFFF_FFFE_0000_0001);
    run_mul(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 1'b0, 0);
    chk_const("mult_neg", 64'hFFFF_FFFF_FFFF_FFEB);
    run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 0);
    chk_const("mult_min", 64'h4000_0000_0000_0000);
    wr(2'b10, 32'h1234_5678);
    wr(2'b11, 32'hCAFE_F00D);
    wr(2'b10, 32'h0);
    wr(2'b01, 32'hFFFF_FFFF);
    run_mul(32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 0);
    chk_const("madd_carry", 64'h0000_0001_0000_0000);
    wr(2'b11, 32'h0);
    run_mul(32'd1, 32'd1, 1'b0, 1'b1, 1'b1, 0);
    chk_const("msub_borrow", 64'hFFFF_FFFF_FFFF_FFFF);
    wr(2'b11, 32'h10);
    run_mul(32'd3, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1);
    run_mul(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 0);

    // Reset while in CALC cycle 5.
    wr(2'b11, 32'h5555_AAAA);
    @(negedge clk);
    a = 32'd9; b = 32'd9; sign = 1'b0; en_c = 1'b1; add_sub = 1'b0; mul = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); mul = 1'b0;
    end
    rst = 1'b1;
    #1 chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); rst = 1'b0;
    model_hilo = 64'd0;
    #1 chk("rst_mid_state", {hi, lo, 30'd0, busy, done}, 64'd0);
    repeat (N + 4) begin
      @(negedge clk); #1 chk("rst_no_done", {63'd0, done}, 64'd0);
    end
    wr(2'b01, 32'h0BAD_F00D);

    // Randomized mix.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0)
        wr(2'($urandom), $urandom);
      else
        run_mul(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 5) == 0);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
